// File: rtl/uart_tx_strobed.sv
`timescale 1ns/1ps
// uart_tx_strobed
// Serial UART transmitter paced by an external bit-rate strobe (one pulse per
// bit period). Frames are start bit, DATA_BITS data bits LSB-first, optional
// parity and STOP_BITS stop bits. Every line transition is aligned to a
// strobe, so each bit lasts exactly one strobe period.
module uart_tx_strobed #(
    parameter int DATA_BITS = 8,  // 5..9
    parameter int PARITY    = 0,  // 0 none, 1 odd, 2 even
    parameter int STOP_BITS = 1   // 1..2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_strobe,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_strobed: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_strobed: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_strobed: STOP_BITS must be 1 or 2");
    end

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int IDX_W = $clog2(DATA_BITS);

    // Index of the final data bit; DATA reaches this before leaving.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    // Stop counter terminal value: 0 for one stop bit, 1 for two.
    localparam logic STOP_LAST = (STOP_BITS == 2);

    localparam logic HAS_PARITY = (PARITY != 0);

    // Odd parity is the inverted XOR, so the accumulator simply starts at 1.
    localparam logic PAR_INIT = (PARITY == 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_PAR   = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]           state;
    logic [DATA_BITS-1:0] shift_q;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic                 par_acc;
    logic                 tx_q;

    // Handshake flags are pure decodes of the registered state, so o_ready
    // rises on the same edge that enters IDLE and never glitches on inputs.
    assign o_ready = (state == ST_IDLE);
    assign o_busy  = (state != ST_IDLE);
    assign o_tx    = tx_q;

    // Frame sequencer and datapath: one transition per strobe after LOAD.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the shift and parity registers are a handful of flops, not
            // a memory, so they are reset along with the control state; this
            // keeps a dropped frame from leaving stale data observable.
            state    <= ST_IDLE;
            shift_q  <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            par_acc  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge values (e.g. shift_q[0] is the bit being sent, not
            // the bit after this edge's shift).
            case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    // A strobe in the accept cycle is deliberately ignored:
                    // the start bit waits for the next full strobe period.
                    if (i_valid) begin
                        shift_q  <= i_data;
                        par_acc  <= PAR_INIT;
                        bit_idx  <= '0;
                        stop_cnt <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (i_strobe) begin
                        tx_q  <= 1'b0;
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (i_strobe) begin
                        tx_q    <= shift_q[0];
                        par_acc <= par_acc ^ shift_q[0];
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (i_strobe) begin
                        if (bit_idx == LAST_IDX) begin
                            // par_acc now holds the full parity of the word.
                            stop_cnt <= 1'b0;
                            if (HAS_PARITY) begin
                                tx_q  <= par_acc;
                                state <= ST_PAR;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            tx_q    <= shift_q[0];
                            par_acc <= par_acc ^ shift_q[0];
                            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                ST_PAR: begin
                    if (i_strobe) begin
                        tx_q     <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (i_strobe) begin
                        if (stop_cnt == STOP_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            // Saturates at the terminal count; never wraps.
                            stop_cnt <= 1'b1;
                        end
                    end
                end

                default: begin
                    tx_q  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_strobed.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_strobed. Four instances cover the parameter
// sets: 8N1, 8E1, 8O1 and 8N2. Inputs are driven and outputs sampled 1 ns
// after each rising clock edge. Expected frames are hand-written bit vectors,
// bit i = i-th bit on the line (start bit first).
module tb_uart_tx_strobed;

    logic       clk;
    logic       rst_n;
    logic       strobe;
    logic [7:0] data;
    logic       valid0, valid1, valid2, valid3;
    logic       tx0, tx1, tx2, tx3;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic       busy0, busy1, busy2, busy3;

    int checks   = 0;
    int failures = 0;
    int phase    = 0;   // strobe divider phase, strobe when phase == 3
    bit const_hi = 0;   // constant-high strobe (DIV = 1)
    int k;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_strobed #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_strobe(strobe), .i_data(data),
        .i_valid(valid0), .o_ready(rdy0), .o_tx(tx0), .o_busy(busy0));
    uart_tx_strobed #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_strobe(strobe), .i_data(data),
        .i_valid(valid1), .o_ready(rdy1), .o_tx(tx1), .o_busy(busy1));
    uart_tx_strobed #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_o1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_strobe(strobe), .i_data(data),
        .i_valid(valid2), .o_ready(rdy2), .o_tx(tx2), .o_busy(busy2));
    uart_tx_strobed #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_n2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_strobe(strobe), .i_data(data),
        .i_valid(valid3), .o_ready(rdy3), .o_tx(tx3), .o_busy(busy3));

    function automatic logic get_tx(int s);
        case (s)
            0:       return tx0;
            1:       return tx1;
            2:       return tx2;
            default: return tx3;
        endcase
    endfunction

    function automatic logic get_rdy(int s);
        case (s)
            0:       return rdy0;
            1:       return rdy1;
            2:       return rdy2;
            default: return rdy3;
        endcase
    endfunction

    function automatic logic get_busy(int s);
        case (s)
            0:       return busy0;
            1:       return busy1;
            2:       return busy2;
            default: return busy3;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: set this cycle's strobe, advance, sample point 1 ns after edge.
    task automatic cyc();
        strobe = const_hi || (phase == 3);
        phase  = (phase + 1) % 4;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the start edge, then check every clock of the frame.
    // k returns the number of clocks waited for the start edge.
    task automatic frame(string name, int s, logic [15:0] exp, int nbits,
                         int period, output int waited);
        waited = 0;
        while (get_tx(s) !== 1'b0 && waited < 40) begin
            cyc();
            waited++;
        end
        check({name, "_start_seen"}, 32'(get_tx(s)), 32'd0);
        check({name, "_busy"}, 32'(get_busy(s)), 32'd1);
        for (int c = 0; c < nbits * period; c++) begin
            check($sformatf("%s_bit%0d_clk%0d", name, c / period, c % period),
                  32'(get_tx(s)), 32'(exp[c / period]));
            if (c == nbits * period - 1)
                check({name, "_ready_before_end"}, 32'(get_rdy(s)), 32'd0);
            cyc();
        end
        check({name, "_ready_at_end"}, 32'(get_rdy(s)), 32'd1);
        check({name, "_idle_line"}, 32'(get_tx(s)), 32'd1);
    endtask

    initial begin
        rst_n  = 1'b0;
        strobe = 1'b0;
        data   = 8'h00;
        valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0; valid3 = 1'b0;
        repeat (3) cyc();

        // Reset state
        check("rst_tx",    32'(tx0),   32'd1);
        check("rst_ready", 32'(rdy0),  32'd1);
        check("rst_busy",  32'(busy0), 32'd0);
        check("rst_tx_n2", 32'(tx3),   32'd1);
        #2 rst_n = 1'b1;
        repeat (2) cyc();

        // 8N1, strobe every 4 clocks, 0x55 -> 0,1,0,1,0,1,0,1,0,1
        phase = 0;
        data = 8'h55; valid0 = 1'b1;
        cyc();
        valid0 = 1'b0;
        check("n1_busy_after_accept", 32'(busy0), 32'd1);
        frame("n1_55", 0, 16'b10_1010_1010, 10, 4, k);
        check("n1_55_latency", 32'(k), 32'd3);
        repeat (3) cyc();

        // 8E1, 0x07 -> parity bit 1 after bit 7
        phase = 0;
        data = 8'h07; valid1 = 1'b1;
        cyc();
        valid1 = 1'b0;
        frame("e1_07", 1, 16'b110_0000_1110, 11, 4, k);
        repeat (3) cyc();

        // 8O1, 0x07 -> parity bit 0
        phase = 0;
        data = 8'h07; valid2 = 1'b1;
        cyc();
        valid2 = 1'b0;
        frame("o1_07", 2, 16'b100_0000_1110, 11, 4, k);
        repeat (3) cyc();

        // 8N2, valid held high, 0xA3 then 0x3C back-to-back
        phase = 0;
        data = 8'hA3; valid3 = 1'b1;
        cyc();
        data = 8'h3C;
        frame("n2_a3", 3, 16'b111_0100_0110, 11, 4, k);
        cyc();
        check("n2_ready_one_cycle", 32'(rdy3), 32'd0);
        valid3 = 1'b0;
        frame("n2_3c", 3, 16'b110_0111_1000, 11, 4, k);
        check("n2_gap_clocks", 32'(k), 32'd3);
        repeat (3) cyc();

        // Accept and strobe in the same cycle; data changed after accept
        phase = 3;
        data = 8'h12; valid0 = 1'b1;
        cyc();
        valid0 = 1'b0;
        data = 8'hFF;
        check("same_cycle_no_start", 32'(tx0), 32'd1);
        frame("n1_12", 0, 16'b10_0010_0100, 10, 4, k);
        check("same_cycle_latency", 32'(k), 32'd4);
        repeat (3) cyc();

        // Constant-high strobe, 0x81 -> 10-clock frame
        const_hi = 1'b1;
        data = 8'h81; valid0 = 1'b1;
        cyc();
        valid0 = 1'b0;
        frame("n1_81_div1", 0, 16'b11_0000_0010, 10, 1, k);
        check("div1_latency", 32'(k), 32'd1);
        const_hi = 1'b0;
        repeat (3) cyc();

        // Reset during data bit 3 of 0x00
        phase = 0;
        data = 8'h00; valid0 = 1'b1;
        cyc();
        valid0 = 1'b0;
        k = 0;
        while (tx0 !== 1'b0 && k < 40) begin
            cyc();
            k++;
        end
        check("rst_mid_start_seen", 32'(tx0), 32'd0);
        repeat (17) cyc();
        check("rst_mid_busy_before", 32'(busy0), 32'd1);
        check("rst_mid_bit3", 32'(tx0), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_async",   32'(tx0),   32'd1);
        check("rst_mid_busy_async", 32'(busy0), 32'd0);
        #2 rst_n = 1'b1;
        cyc();
        check("rst_mid_ready_after", 32'(rdy0), 32'd1);
        check("rst_mid_idle_line",   32'(tx0),  32'd1);
        phase = 0;
        data = 8'h00; valid0 = 1'b1;
        cyc();
        valid0 = 1'b0;
        frame("n1_00_after_rst", 0, 16'b10_0000_0000, 10, 4, k);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
